// File: rtl/proc_pkg.sv
// Shared encodings for the memory/writeback stage of the multi-cycle core.
package proc_pkg;

  typedef enum logic [1:0] {
    OP_ALU   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_NOP   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQ      = 2'b01,
    WAIT_RSP = 2'b10
  } wb_state_t;

endpackage

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: retires ALU results, issues load/store requests with a
// valid/ready handshake, waits for load data with a timeout and drives the RF write port.
module mem_wb_stage
  import proc_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 15,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [REG_AW-1:0] in_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  wb_state_t         state, state_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [REG_AW-1:0] rd_q;
  op_t               op_in;
  logic              accept;
  logic              is_mem_op;
  logic              in_rd_ok;
  logic              rd_q_ok;

  assign op_in     = op_t'(in_op);
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign is_mem_op = (op_in == OP_LOAD) || (op_in == OP_STORE);

  // Register 0 is hard-wired to zero in the register file when ZERO_REG is set.
  assign in_rd_ok = !((ZERO_REG != 0) && (in_rd == '0));
  assign rd_q_ok  = !((ZERO_REG != 0) && (rd_q == '0));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    unique case (state)
      IDLE: begin
        if (accept && is_mem_op) state_nxt = REQ;
      end
      REQ: begin
        if (mem_req_ready) begin
          state_nxt = mem_req_we ? IDLE : WAIT_RSP;
          count_nxt = '0;
        end
      end
      WAIT_RSP: begin
        // A response arriving on the final count still wins over the timeout.
        if (mem_rsp_valid || (count == LAST_CNT)) state_nxt = IDLE;
        else                                     count_nxt = count + CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      rd_q          <= '0;
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      timeout_err   <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (op_in == OP_ALU) begin
              rf_we    <= in_rd_ok;
              rf_waddr <= in_rd;
              rf_wdata <= in_result;
            end else if (is_mem_op) begin
              mem_req_valid <= 1'b1;
              mem_req_we    <= (op_in == OP_STORE);
              mem_req_addr  <= in_result[ADDR_W-1:0];
              mem_req_wdata <= in_store_data;
              rd_q          <= in_rd;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) mem_req_valid <= 1'b0;
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            rf_we    <= rd_q_ok;
            rf_waddr <= rd_q;
            rf_wdata <= mem_rsp_data;
          end else if (count == LAST_CNT) begin
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed ops push expected RF writes and
// memory requests; a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_wb_stage;
  import proc_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int REG_AW = 5;

  typedef struct {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W-1:0] in_store_data;
  logic [REG_AW-1:0] in_rd;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy;
  logic              timeout_err;

  int   checks = 0;
  int   errors = 0;
  wr_t  wr_q[$];
  req_t req_q[$];

  mem_wb_stage #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .MAX_WAIT(15), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_result(in_result), .in_store_data(in_store_data), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation for a single accept edge and records what it should produce.
  task automatic applyStimulus(input op_t op, input logic [DATA_W-1:0] result,
                               input logic [DATA_W-1:0] sdata, input logic [REG_AW-1:0] rd);
    wr_t  w;
    req_t r;
    checkOutput("in_ready before issue", {31'b0, in_ready}, 32'd1);
    in_valid      = 1'b1;
    in_op         = op;
    in_result     = result;
    in_store_data = sdata;
    in_rd         = rd;
    if (op == OP_ALU && rd != '0) begin
      w.rd = rd; w.data = result; wr_q.push_back(w);
    end
    if (op == OP_LOAD || op == OP_STORE) begin
      r.we = (op == OP_STORE); r.addr = result[ADDR_W-1:0]; r.wdata = sdata;
      req_q.push_back(r);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic expectWrite(input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] data);
    wr_t w;
    w.rd = rd; w.data = data;
    wr_q.push_back(w);
  endtask

  // Monitor: every RF write and memory handshake is matched against the scoreboard.
  initial begin
    wr_t  w;
    req_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (rf_we) begin
          if (wr_q.size() == 0) begin
            checkOutput("unexpected rf_we", {31'b0, rf_we}, 32'd0);
          end else begin
            w = wr_q.pop_front();
            checkOutput("rf_waddr", {27'b0, rf_waddr}, {27'b0, w.rd});
            checkOutput("rf_wdata", rf_wdata, w.data);
          end
        end
        if (mem_req_valid && mem_req_ready) begin
          if (req_q.size() == 0) begin
            checkOutput("unexpected mem handshake", {31'b0, mem_req_valid}, 32'd0);
          end else begin
            r = req_q.pop_front();
            checkOutput("mem_req_we", {31'b0, mem_req_we}, {31'b0, r.we});
            checkOutput("mem_req_addr", {16'b0, mem_req_addr}, {16'b0, r.addr});
            checkOutput("mem_req_wdata", mem_req_wdata, r.wdata);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_op = OP_NOP; in_result = '0; in_store_data = '0;
    in_rd = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    step(); step();
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    checkOutput("reset rf_we", {31'b0, rf_we}, 32'd0);
    checkOutput("reset timeout_err", {31'b0, timeout_err}, 32'd0);
    rst_n = 1'b0;
    step();

    // ALU burst: one retire per cycle, in_ready never drops.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(OP_ALU, 32'h11 * i, 32'h0, REG_AW'(i));
      checkOutput("alu rf_we pulse", {31'b0, rf_we}, 32'd1);
    end
    checkOutput("alu busy", {31'b0, busy}, 32'd0);
    step();
    checkOutput("alu rf_we drops", {31'b0, rf_we}, 32'd0);

    // NOP and ALU to r0 produce no write.
    applyStimulus(OP_NOP, 32'h99, 32'h0, 5'd4);
    checkOutput("nop busy", {31'b0, busy}, 32'd0);
    applyStimulus(OP_ALU, 32'h77, 32'h0, 5'd0);
    step();

    // Zero-wait load: request in k+1, write in k+3.
    mem_req_ready = 1'b1;
    applyStimulus(OP_LOAD, 32'h0040, 32'h0, 5'd5);
    checkOutput("load k+1 busy", {31'b0, busy}, 32'd1);
    checkOutput("load k+1 req_valid", {31'b0, mem_req_valid}, 32'd1);
    step();
    mem_req_ready = 1'b0;
    checkOutput("load k+2 busy", {31'b0, busy}, 32'd1);
    checkOutput("load k+2 req_valid", {31'b0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
    expectWrite(5'd5, 32'hDEADBEEF);
    step();
    mem_rsp_valid = 1'b0;
    checkOutput("load k+3 rf_we", {31'b0, rf_we}, 32'd1);
    checkOutput("load k+3 busy", {31'b0, busy}, 32'd0);
    step();

    // Store under backpressure: request held stable for 4 cycles.
    applyStimulus(OP_STORE, 32'h0100, 32'hCAFE, 5'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("store hold valid", {31'b0, mem_req_valid}, 32'd1);
      checkOutput("store hold we", {31'b0, mem_req_we}, 32'd1);
      checkOutput("store hold addr", {16'b0, mem_req_addr}, 32'h0100);
      checkOutput("store hold wdata", mem_req_wdata, 32'hCAFE);
      if (i < 3) step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    checkOutput("store done busy", {31'b0, busy}, 32'd0);
    checkOutput("store done valid", {31'b0, mem_req_valid}, 32'd0);

    // Response on the final count cycle wins over the timeout.
    mem_req_ready = 1'b1;
    applyStimulus(OP_LOAD, 32'h0300, 32'h0, 5'd9);
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 14; i++) step();
    checkOutput("final count busy", {31'b0, busy}, 32'd1);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA5A5A5A5;
    expectWrite(5'd9, 32'hA5A5A5A5);
    step();
    mem_rsp_valid = 1'b0;
    checkOutput("final count busy after", {31'b0, busy}, 32'd0);
    checkOutput("final count no timeout", {31'b0, timeout_err}, 32'd0);
    step();

    // Load into r0: the memory transaction happens but nothing is written.
    mem_req_ready = 1'b1;
    applyStimulus(OP_LOAD, 32'h0044, 32'h0, 5'd0);
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555AAAA;
    step();
    mem_rsp_valid = 1'b0;
    checkOutput("r0 load rf_we", {31'b0, rf_we}, 32'd0);
    checkOutput("r0 load busy", {31'b0, busy}, 32'd0);

    // Timeout after 15 WAIT_RSP cycles, then a late response is ignored.
    mem_req_ready = 1'b1;
    applyStimulus(OP_LOAD, 32'h0200, 32'h0, 5'd7);
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (busy !== 1'b1 || timeout_err !== 1'b0)
        checkOutput("timeout wait state", {30'b0, busy, timeout_err}, 32'd2);
      step();
    end
    checkOutput("timeout busy", {31'b0, busy}, 32'd0);
    checkOutput("timeout_err set", {31'b0, timeout_err}, 32'd1);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234;
    step();
    mem_rsp_valid = 1'b0;
    step();
    checkOutput("late rsp timeout sticky", {31'b0, timeout_err}, 32'd1);
    checkOutput("late rsp busy", {31'b0, busy}, 32'd0);

    // Reset in the middle of a pending request.
    applyStimulus(OP_STORE, 32'h0055, 32'h66, 5'd0);
    void'(req_q.pop_back());
    checkOutput("pre-reset req_valid", {31'b0, mem_req_valid}, 32'd1);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("async reset req_valid", {31'b0, mem_req_valid}, 32'd0);
    step();
    rst_n = 1'b0;
    step();
    checkOutput("post-reset in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("post-reset busy", {31'b0, busy}, 32'd0);
    checkOutput("post-reset timeout_err", {31'b0, timeout_err}, 32'd0);

    step();
    checkOutput("write queue drained", wr_q.size(), 32'd0);
    checkOutput("request queue drained", req_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
